// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point DIT FFT datapath.
// Holds the transform size, the bit-reversal lane mapping and the
// encoding of the input-reorder FSM states.
package fft_pkg;

  localparam int N_POINTS = 8;
  localparam int LOG2_N   = 3;

  // Count value of the last sample in a frame
  localparam logic [LOG2_N-1:0] LAST_CNT = 3'd7;

  // Reorder FSM encoding
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // Reverse the three index bits: sample n lands in lane bitrev3(n)
  function automatic logic [2:0] bitrev3(input logic [2:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/fft_input_reorder.sv
// Input stage of the 8-point DIT FFT. Collects eight complex samples from a
// valid/ready stream into bit-reversed lanes and then presents the whole
// frame in parallel until the first butterfly stage takes it.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 8,
  parameter int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          in_real,
  input  logic [DATA_WIDTH-1:0]          in_imag,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [N_POINTS*DATA_WIDTH-1:0] out_real,
  output logic [N_POINTS*DATA_WIDTH-1:0] out_imag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           frame_err
);

  logic [0:0]            state;
  logic [LOG2_N-1:0]     cnt;
  logic                  accept;
  logic [N_POINTS-1:0]   lane_sel;
  logic [DATA_WIDTH-1:0] lane_real [N_POINTS];
  logic [DATA_WIDTH-1:0] lane_imag [N_POINTS];

  // Handshake flags come straight from the state register, so in_ready has
  // no combinational dependence on out_ready
  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // One-hot write enable for the lane addressed by the bit-reversed count
  always_comb begin
    lane_sel = '0;
    lane_sel[bitrev3(cnt)] = 1'b1;
  end

  // FSM and sample counter: framing is by count alone, in_last never matters here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            cnt <= cnt + 3'd1;
            if (cnt == LAST_CNT) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Lane registers only change on accepted samples, so they stay frozen in HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_POINTS; k++) begin
        lane_real[k] <= '0;
        lane_imag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_POINTS; k++) begin
        if (accept && lane_sel[k]) begin
          lane_real[k] <= in_real;
          lane_imag[k] <= in_imag;
        end
      end
    end
  end

  // Sticky flag for in_last disagreeing with the sample count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (accept && (in_last != (cnt == LAST_CNT))) begin
      frame_err <= 1'b1;
    end
  end

  // Flatten the lanes onto the parallel output buses
  for (genvar k = 0; k < N_POINTS; k++) begin : g_lane_out
    assign out_real[k*DATA_WIDTH +: DATA_WIDTH] = lane_real[k];
    assign out_imag[k*DATA_WIDTH +: DATA_WIDTH] = lane_imag[k];
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Directed testbench for fft_input_reorder: reset, ordered frame,
// backpressure, gapped input, bad framing and reset in the middle of a fill.
module tb_fft_input_reorder;

  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   in_real;
  logic [DW-1:0]   in_imag;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [8*DW-1:0] out_real;
  logic [8*DW-1:0] out_imag;
  logic            out_valid;
  logic            out_ready;
  logic            frame_err;

  int total = 0;
  int bad   = 0;

  // Sample index held by each lane after a complete frame
  int order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_input_reorder #(
    .INT_WIDTH  (8),
    .FRACT_WIDTH(8),
    .DATA_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_real (out_real),
    .out_imag (out_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of input starting at a falling edge, return at the next falling edge
  task automatic drive(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                       input logic last);
    in_valid = v;
    in_real  = re;
    in_imag  = im;
    in_last  = last;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_real  = '0;
    in_imag  = '0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) drive(1'b1, 16'h1234 + 16'(n), 16'h4321, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", frame_err); end
    total++; if (out_real !== '0) begin bad++; $display("[TB] FAIL reset_real: got %h want 0", out_real); end
    total++; if (out_imag !== '0) begin bad++; $display("[TB] FAIL reset_imag: got %h want 0", out_imag); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_ordered();
    logic [DW-1:0] exp_re;
    logic [DW-1:0] exp_im;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (n == 7) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ordered_early_valid: got %b want 0", out_valid); end
      end
      drive(1'b1, 16'(n * 256), 16'(-(n * 256)), n == 7);
    end
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL ordered_valid: got %b want 1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ordered_ready_hold: got %b want 0", in_ready); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL ordered_err: got %b want 0", frame_err); end
    for (int k = 0; k < 8; k++) begin
      exp_re = 16'(order[k] * 256);
      exp_im = 16'(-(order[k] * 256));
      total++; if (out_real[k*DW +: DW] !== exp_re) begin bad++; $display("[TB] FAIL ordered_real lane%0d: got %h want %h", k, out_real[k*DW +: DW], exp_re); end
      total++; if (out_imag[k*DW +: DW] !== exp_im) begin bad++; $display("[TB] FAIL ordered_imag lane%0d: got %h want %h", k, out_imag[k*DW +: DW], exp_im); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ordered_one_cycle: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ordered_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [8*DW-1:0] exp_re;
    logic [8*DW-1:0] exp_im;
    for (int k = 0; k < 8; k++) begin
      exp_re[k*DW +: DW] = 16'h1000 + 16'(order[k]);
      exp_im[k*DW +: DW] = 16'h2000 + 16'(order[k]);
    end
    out_ready = 1'b0;
    for (int n = 0; n < 8; n++) drive(1'b1, 16'h1000 + 16'(n), 16'h2000 + 16'(n), n == 7);
    for (int c = 0; c < 5; c++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid c%0d: got %b want 1", c, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready c%0d: got %b want 0", c, in_ready); end
      total++; if (out_real !== exp_re) begin bad++; $display("[TB] FAIL bp_real c%0d: got %h want %h", c, out_real, exp_re); end
      total++; if (out_imag !== exp_im) begin bad++; $display("[TB] FAIL bp_imag c%0d: got %h want %h", c, out_imag, exp_im); end
      drive(1'b1, 16'hAAAA, 16'hBBBB, 1'b0);
    end
    out_ready = 1'b1;
    drive(1'b1, 16'hCCCC, 16'hDDDD, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
    total++; if (out_real !== exp_re) begin bad++; $display("[TB] FAIL bp_no_consume: got %h want %h", out_real, exp_re); end
    drive(1'b1, 16'h5A5A, 16'hA5A5, 1'b0);
    total++; if (out_real[0 +: DW] !== 16'h5A5A) begin bad++; $display("[TB] FAIL bp_first_lane0: got %h want 5a5a", out_real[0 +: DW]); end
    total++; if (out_imag[0 +: DW] !== 16'hA5A5) begin bad++; $display("[TB] FAIL bp_first_lane0_imag: got %h want a5a5", out_imag[0 +: DW]); end
    total++; if (out_real[8*DW-1:DW] !== exp_re[8*DW-1:DW]) begin bad++; $display("[TB] FAIL bp_other_lanes: got %h want %h", out_real[8*DW-1:DW], exp_re[8*DW-1:DW]); end
    for (int n = 1; n < 8; n++) drive(1'b1, 16'h5A5A + 16'(n), 16'hA5A5, n == 7);
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_next_frame: got %b want 1", out_valid); end
    total++; if (out_real[7*DW +: DW] !== 16'h5A61) begin bad++; $display("[TB] FAIL bp_next_lane7: got %h want 5a61", out_real[7*DW +: DW]); end
    @(negedge clk);
  endtask

  task automatic test_gapped();
    logic [23:0] pat;
    int n;
    logic [DW-1:0] exp_re;
    pat = 24'b1001_0110_1100_1010_0111_0101;
    n = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 24 && n < 8; i++) begin
      drive(pat[i], 16'(n * 256 + 'h11), 16'h8000 | 16'(n), n == 7);
      if (pat[i]) n++;
    end
    idle();
    total++; if (n != 8) begin bad++; $display("[TB] FAIL gapped_budget: got %0d want 8", n); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL gapped_valid: got %b want 1", out_valid); end
    for (int k = 0; k < 8; k++) begin
      exp_re = 16'(order[k] * 256 + 'h11);
      total++; if (out_real[k*DW +: DW] !== exp_re) begin bad++; $display("[TB] FAIL gapped_real lane%0d: got %h want %h", k, out_real[k*DW +: DW], exp_re); end
      total++; if (out_imag[k*DW +: DW] !== (16'h8000 | 16'(order[k]))) begin bad++; $display("[TB] FAIL gapped_imag lane%0d: got %h want %h", k, out_imag[k*DW +: DW], 16'h8000 | 16'(order[k])); end
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL gapped_release: got %b want 0", out_valid); end
  endtask

  task automatic test_bad_framing();
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (n == 5) begin
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL bad_err_before: got %b want 0", frame_err); end
      end
      drive(1'b1, 16'h0040 + 16'(n), 16'h0080 + 16'(n), n == 5);
      if (n == 5) begin
        total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL bad_err_set: got %b want 1", frame_err); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bad_no_short: got %b want 0", out_valid); end
      end
    end
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bad_frame_done: got %b want 1", out_valid); end
    total++; if (out_real[7*DW +: DW] !== 16'h0047) begin bad++; $display("[TB] FAIL bad_lane7: got %h want 0047", out_real[7*DW +: DW]); end
    @(negedge clk);
    for (int n = 0; n < 8; n++) drive(1'b1, 16'(n), 16'(n), n == 7);
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bad_good_frame: got %b want 1", out_valid); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL bad_err_sticky: got %b want 1", frame_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_midfill();
    logic [DW-1:0] exp_re;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    total++; if (out_real !== '0) begin bad++; $display("[TB] FAIL midfill_clear: got %h want 0", out_real); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midfill_err_clear: got %b want 0", frame_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 8; n++) drive(1'b1, 16'(n * 256 + 'h22), 16'h7000 + 16'(n), n == 7);
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL midfill_valid: got %b want 1", out_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midfill_err: got %b want 0", frame_err); end
    for (int k = 0; k < 8; k++) begin
      exp_re = 16'(order[k] * 256 + 'h22);
      total++; if (out_real[k*DW +: DW] !== exp_re) begin bad++; $display("[TB] FAIL midfill_real lane%0d: got %h want %h", k, out_real[k*DW +: DW], exp_re); end
      total++; if (out_imag[k*DW +: DW] !== 16'h7000 + 16'(order[k])) begin bad++; $display("[TB] FAIL midfill_imag lane%0d: got %h want %h", k, out_imag[k*DW +: DW], 16'h7000 + 16'(order[k])); end
    end
    @(negedge clk);
  endtask

  // Test sequence
  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_ordered();
    test_back_to_back_backpressure();
    test_gapped();
    test_bad_framing();
    test_reset_midfill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_input_reorder.md
# fft_input_reorder

Upstream input stage of the 8-point DIT FFT. It accepts one complex fixed-point sample per transfer over a valid/ready stream and writes each sample to its bit-reversed lane. Once 8 samples are collected, it presents the whole frame in parallel to the first butterfly stage. The frame is held until the downstream stage accepts it.

## Interface
- INT_WIDTH, 8, integer field width (same format as the butterfly datapath)
- FRACT_WIDTH, 8, fractional field width
- DATA_WIDTH, INT_WIDTH + FRACT_WIDTH, sample word width
- clk  in  1  single clock, rising edge
- rst  in  1  reset: asynchronous, active-high
- in_real  in  DATA_WIDTH  input sample, real part
- in_imag  in  DATA_WIDTH  input sample, imaginary part
- in_valid  in  1  input sample present
- in_last  in  1  marks the 8th sample of a frame (checked only)
- in_ready  out  1  block can accept a sample
- out_real  out  8*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH]
- out_imag  out  8*DATA_WIDTH  same lane layout as out_real
- out_valid  out  1  full reordered frame present
- out_ready  in  1  downstream accepts the frame
- frame_err  out  1  sticky in_last misalignment flag

## Operation
- Two-state FSM:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Sample accept: in_valid & in_ready at a clk edge.
- Sample counter: 3-bit cnt, 0..7. On accept, the sample is written to lane bitrev3(cnt), then cnt increments.
- Resulting lane order: lane0..7 = x0, x4, x2, x6, x1, x5, x3, x7.
- The accept with cnt==7 writes lane 7, wraps cnt to 0 and moves to HOLD.
- HOLD:
  - out_real/out_imag are frozen; in_valid is ignored.
  - On out_valid & out_ready, the FSM returns to FILL.
  - Lane registers are not cleared on leaving HOLD; the next frame overwrites all 8 lanes.
- Framing is by count only; in_last never shortens or extends a frame.
- frame_err is set on either of these accepts, and stays set until rst:
  - in_last=1 with cnt!=7
  - cnt==7 with in_last=0
- No arithmetic: samples pass bit-exact, no sign extension or rounding.
- Reset (asynchronous, any state, including mid-fill or mid-hold):
  - FSM to FILL, cnt=0.
  - All lane registers 0; out_real=0, out_imag=0.
  - out_valid=0, in_ready=1, frame_err=0.
  - A partial frame is discarded.

## Timing
- Latency: out_valid rises in the cycle right after the edge that accepts the 8th sample.
- out_valid is registered (FSM state). in_ready is decoded directly from FSM state only; it has no combinational path from out_ready.
- Hold-to-fill: after the edge where out_valid & out_ready, in_ready=1 in the next cycle. This gives exactly one cycle with no input accept per frame.
- Peak throughput: 1 frame per 9 cycles.
- If out_ready is already high when out_valid rises, HOLD lasts exactly 1 cycle.
- Output lanes change only on accept edges in FILL. While out_valid=1 they are stable.

## Structure
- Shared package fft_pkg holds:
  - N_POINTS=8 and LOG2_N=3
  - the bitrev3 function / constant lane map
  - FSM state encoding (FILL, HOLD)
- Lane write uses a one-hot decode of bitrev3(cnt) over 8 registered lanes.
- Single module; no sub-module is needed.

## Test plan
- Reset: assert rst with random state -> out_valid=0, in_ready=1, frame_err=0, all out lanes 0x0000.
- Ordered frame: out_ready=1, samples n=0..7 sent back-to-back with in_real=n*0x0100, in_imag=-n*0x0100, in_last on n=7.
  - Lanes real = 0x0000, 0x0400, 0x0200, 0x0600, 0x0100, 0x0500, 0x0300, 0x0700.
  - out_valid rises in the cycle after the 8th accept and holds for 1 cycle; frame_err=0.
- Backpressure: full frame with out_ready=0 for 5 cycles while in_valid=1.
  - Lanes stable; in_ready=0; no sample consumed.
  - Raise out_ready -> one transfer, in_ready=1 next cycle.
  - The first sample after that lands in lane0.
- Gapped input: in_valid toggled in a random pattern -> only accepted samples counted; lane order identical to the ordered-frame test.
- Bad framing: in_last on sample 5 -> frame_err=1 at the next edge. The frame still completes after 8 accepts, and frame_err stays 1 through the following correct frame.
- Reset mid-fill: rst pulsed after 3 accepts -> cnt restarts. The next 8 samples produce a correct frame with no trace of the discarded samples.
